// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and counter sizing.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit counter must hold 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor.
// Latency: none (wires only).
// Backpressure: none; start is only honoured while the block is idle.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
module fs_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
// Latency: done high in the cycle after edge WIDTH (start edge = edge 0); issue interval WIDTH+2.
// Backpressure: start is ignored while busy; results are held until the next completion.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic cell_d;
    logic cell_bout;

    fs_bit_cell u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Result bits refill the minuend register from the top as it drains.
                a_sr_d   = {cell_d, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    diff_d  = {cell_d, a_sr_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: transaction-level model plus directed vectors.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic cx, cy, cb, cd, cbo;
    fs_bit_cell u_cell_tb (
        .x    (cx),
        .y    (cy),
        .bin  (cb),
        .d    (cd),
        .bout (cbo)
    );

    int checks   = 0;
    int failures = 0;

    // Model: edges remaining until idle, and the result due at completion.
    int          m_remain = 0;
    logic [W-1:0] m_a, m_b;
    logic [W-1:0] m_diff = '0;
    logic        m_bo = 1'b0;
    bit          m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] d, output logic bo,
                          output int lat, output int busy_cnt);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        d = '0;
        bo = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done && lat < 0) begin
                lat = n;
                d = bus.diff;
                bo = bus.borrow_out;
            end
            if (!bus.busy) break;
            @(posedge clk); #1;
        end
    endtask

    logic [W-1:0] r_d;
    logic         r_bo;
    int           r_lat, r_busy, dones, first_done, last_done;
    logic [1:0]   cell_exp [8];
    logic [7:0]   va [4];
    logic [7:0]   vb [4];
    logic [7:0]   vd [4];
    logic         vbo [4];

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        cx = 1'b0; cy = 1'b0; cb = 1'b0;

        fork
            forever begin
                @(posedge clk);
                if (rst) begin
                    m_remain = 0; m_diff = '0; m_bo = 1'b0; m_valid = 1'b1;
                end else if (m_remain > 0) begin
                    m_remain--;
                    if (m_remain == 1) begin
                        m_diff = m_a - m_b;
                        m_bo = (m_a < m_b);
                    end
                end else if (bus.start) begin
                    m_remain = W + 1;
                    m_a = bus.a;
                    m_b = bus.b;
                end
            end
            forever begin
                @(negedge clk);
                if (m_valid)
                    check("cycle busy/done/borrow/diff",
                          {21'd0, bus.busy, bus.done, bus.borrow_out, bus.diff},
                          {21'd0, (m_remain > 0), (m_remain == 1), m_bo, m_diff});
            end
        join_none

        cell_exp[0] = 2'b00; cell_exp[1] = 2'b11; cell_exp[2] = 2'b11; cell_exp[3] = 2'b01;
        cell_exp[4] = 2'b10; cell_exp[5] = 2'b00; cell_exp[6] = 2'b00; cell_exp[7] = 2'b11;
        for (int i = 0; i < 8; i++) begin
            {cx, cy, cb} = 3'(i);
            #1;
            check($sformatf("cell xyb=%0d", i), {30'd0, cd, cbo}, {30'd0, cell_exp[i]});
        end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset outputs", {21'd0, bus.busy, bus.done, bus.borrow_out, bus.diff}, 32'd0);

        run_op(8'h05, 8'h03, r_d, r_bo, r_lat, r_busy);
        check("05-03 done edge", r_lat, W);
        check("05-03 busy cycles", r_busy, W + 1);
        check("05-03 diff", {24'd0, r_d}, 32'h02);
        check("05-03 borrow", {31'd0, r_bo}, 32'd0);

        va[0] = 8'h03; vb[0] = 8'h05; vd[0] = 8'hFE; vbo[0] = 1'b1;
        va[1] = 8'h00; vb[1] = 8'h01; vd[1] = 8'hFF; vbo[1] = 1'b1;
        va[2] = 8'hFF; vb[2] = 8'hFF; vd[2] = 8'h00; vbo[2] = 1'b0;
        va[3] = 8'h01; vb[3] = 8'h80; vd[3] = 8'h81; vbo[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], r_d, r_bo, r_lat, r_busy);
            check($sformatf("vec%0d done edge", i), r_lat, W);
            check($sformatf("vec%0d diff", i), {24'd0, r_d}, {24'd0, vd[i]});
            check($sformatf("vec%0d borrow", i), {31'd0, r_bo}, {31'd0, vbo[i]});
        end

        // start while busy must be ignored
        bus.a = 8'h80; bus.b = 8'h01; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.a = 8'hAA; bus.b = 8'h11; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        dones = 0;
        for (int n = 0; n < 40 && bus.busy; n++) begin
            if (bus.done) begin
                dones++;
                r_d = bus.diff;
                r_bo = bus.borrow_out;
            end
            @(posedge clk); #1;
        end
        check("ignored start done pulses", dones, 1);
        check("ignored start diff", {24'd0, r_d}, 32'h7F);
        check("ignored start borrow", {31'd0, r_bo}, 32'd0);
        check("ignored start idle", {31'd0, bus.busy}, 32'd0);

        // reset in the middle of an operation
        bus.a = 8'h55; bus.b = 8'h22; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid reset outputs", {21'd0, bus.busy, bus.done, bus.borrow_out, bus.diff}, 32'd0);
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("mid reset no done", dones, 0);
        run_op(8'h10, 8'h01, r_d, r_bo, r_lat, r_busy);
        check("after reset diff", {24'd0, r_d}, 32'h0F);
        check("after reset borrow", {31'd0, r_bo}, 32'd0);

        // back-to-back with start held high
        bus.a = 8'h09; bus.b = 8'h04; bus.start = 1'b1;
        dones = 0; first_done = -1; last_done = -1;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                dones++;
                if (first_done < 0) first_done = n;
                else check("b2b spacing", n - last_done, W + 2);
                last_done = n;
                check("b2b diff", {24'd0, bus.diff}, 32'h05);
            end
        end
        bus.start = 1'b0;
        check("b2b pulse count", dones, 3);
        check("b2b first done", first_done, W);
        begin
            int k;
            k = 0;
            while (bus.busy && k < 30) begin
                @(posedge clk); #1;
                k++;
            end
            check("b2b returns idle", {31'd0, bus.busy}, 32'd0);
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor that computes a - b, LSB first, one bit per clock.
Each bit uses a single full-subtractor bit cell; a borrow flip-flop carries the borrow from one bit to the next.
It sits directly upstream of result consumers and replaces a WIDTH-wide combinational ripple subtractor where area matters more than latency.
Operands are captured on a start handshake; the result is presented with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock; the block's only clock.
rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
start  input  1  request to begin a subtraction; honoured only in IDLE.
a  input  WIDTH  minuend; sampled on the edge where start is accepted.
b  input  WIDTH  subtrahend; sampled on the edge where start is accepted.
busy  output  1  high while a subtraction is in progress (states SHIFT and DONE).
done  output  1  one-cycle pulse; diff and borrow_out are valid in this cycle.
diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next completion.
borrow_out  output  1  final borrow, i.e. 1 when a < b (unsigned); held with diff.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; the a/b shift registers, borrow flop and bit counter clear to 0.
  - busy=0, done=0, diff=0, borrow_out=0.
  - rst takes priority over every other input.
  - Reset mid-operation aborts the subtraction with no done pulse; outputs return to 0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge loads a and b into the shift registers, clears the borrow flop, sets count=0 and moves to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT, at each edge:
  - The bit cell computes, from x=a_sr[0], y=b_sr[0] and borrow-in bin:
    - d = x ^ y ^ bin
    - bout = (~x & y) | (~(x ^ y) & bin)
  - d shifts into the MSB of the result shift register.
  - a_sr and b_sr shift right by one; the borrow flop takes bout; count increments.
  - When count reaches WIDTH-1 at an edge, that edge processes the final bit and the state moves to DONE.
- DONE (exactly one cycle):
  - done=1.
  - diff and borrow_out registers hold the completed result. They are loaded on the edge that enters DONE, so they are already valid during the done cycle.
  - The next edge returns to IDLE.
- Timing:
  - busy=1 from the cycle after start is accepted through the done cycle, inclusive.
  - The start edge is edge 0; done is high during the cycle after edge WIDTH. Total latency is WIDTH+1 cycles from the start edge.
- start while busy (SHIFT or DONE) is ignored: no restart and no corruption of operands in flight.
- Changes to a and b after acceptance have no effect.
- diff and borrow_out change only on the edge entering DONE, or on reset. Between operations they hold the last result.
- Back-to-back operation: start held high through DONE is accepted in the following IDLE cycle. Minimum issue interval is WIDTH+2 cycles.
- The counter width is clog2(WIDTH); it does not wrap in normal operation.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - a clog2-based counter-width helper.
- One natural sub-module, fs_bit_cell: purely combinational inputs (x, y, bin), outputs (d, bout).
  - Instantiated once inside serial_subtractor.
  - Reusable by the future serial adder/comparator.

Test Plan:
- fs_bit_cell exhaustive: all 8 combinations of (x,y,bin) from 000 to 111 -> (d,bout) = 00,11,11,01,10,00,00,11.
- WIDTH=8, a=0x05, b=0x03, start pulse -> done exactly 9 cycles after the start edge; diff=0x02, borrow_out=0; busy high for 9 cycles.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Then a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Then a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
- start re-asserted with a=0xAA, b=0x11 at cycle 3 of an 0x80-0x01 operation -> ignored; diff=0x7F, borrow_out=0; exactly one done pulse.
- rst asserted at cycle 4 of an operation -> next cycle busy=0, done=0, diff=0, borrow_out=0; no done pulse. A following start with 0x10-0x01 gives diff=0x0F.
- start held high continuously with fixed a=0x09, b=0x04 -> done pulses every 10 cycles, diff=0x05 each time; diff stable between pulses.
